// File: rtl/ctr_seq_ctrl_pkg.sv
// Shared op encodings and FSM state type for the counter sequencing controller.
package ctr_seq_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_UP   = 2'b10,
    OP_DOWN = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/ctr_seq_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, last-grant pointer moves on accept.
// Zero latency; a lone request is granted outright, ties go to the side not served last.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  // Reset value 1 means "requester 1 was served last", so requester 0 wins the first tie.
  logic last_q;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else if (accept && (grant != 2'b00)) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/ctr_seq_ctrl.sv
// Sequences LOAD/UP/DOWN commands from two requesters onto a counter datapath.
// Accept T -> done T+2 (LOAD/NOP/0 steps) or T+S+1; req_ready only in IDLE, no queuing.
module ctr_seq_ctrl
  import ctr_seq_pkg::*;
#(
  parameter int N     = 4,
  parameter int STEPW = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [3:0]         req_op,
  input  logic [2*N-1:0]     req_data,
  input  logic [2*STEPW-1:0] req_steps,
  input  logic               abort,
  output logic               cnt_load,
  output logic               cnt_up,
  output logic               cnt_en,
  output logic [N-1:0]       cnt_d,
  input  logic [N-1:0]       cnt_q,
  output logic [1:0]         done,
  output logic               aborted,
  output logic [N-1:0]       rsp_q,
  output logic               busy
);

  state_e           state_q;
  logic [STEPW-1:0] remaining_q;
  logic             id_q;
  logic             load_q;
  logic             en_q;
  logic             up_q;
  logic [N-1:0]     cnt_d_q;
  logic [1:0]       done_q;
  logic             aborted_q;
  logic [N-1:0]     rsp_r;
  logic             busy_q;

  logic [1:0]       grant;
  logic             accept;
  logic             gid;
  op_e              g_op;
  logic [N-1:0]     g_data;
  logic [STEPW-1:0] g_steps;
  logic [N-1:0]     rsp_next;

  assign accept = (state_q == S_IDLE) && (req_valid != 2'b00);

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_valid),
    .accept  (accept),
    .grant   (grant)
  );

  assign req_ready = (state_q == S_IDLE) ? grant : 2'b00;
  assign gid       = grant[1];
  assign g_op      = op_e'(gid ? req_op[3:2] : req_op[1:0]);
  assign g_data    = gid ? req_data[2*N-1:N] : req_data[N-1:0];
  assign g_steps   = gid ? req_steps[2*STEPW-1:STEPW] : req_steps[STEPW-1:0];

  // Abort must kill the strobe in the very cycle it is raised, so the registered
  // strobes pass through one AND gate on their way out.
  assign cnt_load = load_q & ~abort;
  assign cnt_en   = en_q & ~abort;
  assign cnt_up   = up_q;
  assign cnt_d    = cnt_d_q;
  assign done     = done_q;
  assign aborted  = aborted_q;
  assign rsp_q    = rsp_r;
  assign busy     = busy_q;

  // The counter updates on the same edge that enters DONE, so capture the value it
  // will hold during DONE rather than the stale one.
  always_comb begin
    rsp_next = cnt_q;
    if (cnt_load) begin
      rsp_next = cnt_d_q;
    end else if (cnt_en) begin
      rsp_next = up_q ? cnt_q + N'(1) : cnt_q - N'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      id_q        <= 1'b0;
      load_q      <= 1'b0;
      en_q        <= 1'b0;
      up_q        <= 1'b0;
      cnt_d_q     <= '0;
      done_q      <= 2'b00;
      aborted_q   <= 1'b0;
      rsp_r       <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q    <= 2'b00;
          aborted_q <= 1'b0;
          if (accept) begin
            id_q        <= gid;
            remaining_q <= g_steps;
            state_q     <= S_EXEC;
            busy_q      <= 1'b1;
            if (g_op == OP_LOAD) begin
              load_q  <= 1'b1;
              cnt_d_q <= g_data;
            end else if ((g_op == OP_UP || g_op == OP_DOWN) && g_steps != '0) begin
              en_q <= 1'b1;
              up_q <= (g_op == OP_UP);
            end
          end
        end
        S_EXEC: begin
          if (abort || !(en_q && remaining_q > STEPW'(1))) begin
            state_q   <= S_DONE;
            load_q    <= 1'b0;
            en_q      <= 1'b0;
            up_q      <= 1'b0;
            done_q    <= id_q ? 2'b10 : 2'b01;
            aborted_q <= abort;
            rsp_r     <= rsp_next;
          end else begin
            remaining_q <= remaining_q - STEPW'(1);
          end
        end
        S_DONE: begin
          done_q    <= 2'b00;
          aborted_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctr_seq_ctrl.sv
// Directed bench for ctr_seq_ctrl with a behavioural counter datapath closing the loop.
module tb_ctr_seq_ctrl;
  localparam int N = 4;
  localparam int STEPW = 8;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [1:0]         req_valid = '0;
  logic [1:0]         req_ready;
  logic [3:0]         req_op = '0;
  logic [2*N-1:0]     req_data = '0;
  logic [2*STEPW-1:0] req_steps = '0;
  logic               abort = 1'b0;
  logic               cnt_load, cnt_up, cnt_en;
  logic [N-1:0]       cnt_d;
  logic [N-1:0]       cnt_q;
  logic [1:0]         done;
  logic               aborted;
  logic [N-1:0]       rsp_q;
  logic               busy;

  int checks = 0;
  int failures = 0;

  ctr_seq_ctrl #(.N(N), .STEPW(STEPW)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .req_steps(req_steps), .abort(abort),
    .cnt_load(cnt_load), .cnt_up(cnt_up), .cnt_en(cnt_en), .cnt_d(cnt_d),
    .cnt_q(cnt_q), .done(done), .aborted(aborted), .rsp_q(rsp_q), .busy(busy)
  );

  always #5 clk = ~clk;

  // Counter datapath model
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else if (cnt_load) cnt_q <= cnt_d;
    else if (cnt_en) cnt_q <= cnt_up ? cnt_q + 4'd1 : cnt_q - 4'd1;
  end

  typedef struct {
    logic       id;
    logic [1:0] op;
    logic [3:0] data;
    logic [7:0] steps;
    int         abort_at;
    int         lat;
    int         n_en;
    int         n_load;
    logic       up;
    logic [3:0] rsp;
    logic       ab;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(logic id, logic [1:0] op, logic [3:0] data, logic [7:0] steps,
                              int abort_at, int lat, int n_en, int n_load, logic up,
                              logic [3:0] rsp, logic ab);
    vec_t v;
    v.id = id; v.op = op; v.data = data; v.steps = steps; v.abort_at = abort_at;
    v.lat = lat; v.n_en = n_en; v.n_load = n_load; v.up = up; v.rsp = rsp; v.ab = ab;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic id, input logic [1:0] op, input logic [3:0] data,
                         input logic [7:0] steps);
    if (id) begin
      req_op[3:2] = op; req_data[7:4] = data; req_steps[15:8] = steps;
    end else begin
      req_op[1:0] = op; req_data[3:0] = data; req_steps[7:0] = steps;
    end
  endtask

  task automatic run_cmd(input vec_t v);
    int k, done_c, n_en, n_load;
    logic [1:0] exp_rdy;
    exp_rdy = v.id ? 2'b10 : 2'b01;
    @(negedge clk);
    set_req(v.id, v.op, v.data, v.steps);
    req_valid = exp_rdy;
    #1;
    k = 0;
    while (req_ready !== exp_rdy && k < 20) begin
      @(negedge clk); #1; k++;
    end
    chk("accept_ready", req_ready, exp_rdy);
    n_en = 0; n_load = 0; done_c = 0;
    for (int c = 1; c <= 40 && done_c == 0; c++) begin
      @(negedge clk);
      req_valid = '0;
      abort = (c == v.abort_at);
      #1;
      if (c == 1) chk("busy_exec", busy, 1);
      if (cnt_en) begin n_en++; chk("cnt_up_dir", cnt_up, v.up); end
      if (cnt_load) begin n_load++; chk("cnt_d_val", cnt_d, v.data); end
      chk("load_en_excl", cnt_en & cnt_load, 0);
      if (done != 2'b00) done_c = c;
    end
    chk("done_latency", done_c, v.lat);
    chk("done_vec", done, exp_rdy);
    chk("rsp_q", rsp_q, v.rsp);
    chk("aborted", aborted, v.ab);
    chk("n_enables", n_en, v.n_en);
    chk("n_loads", n_load, v.n_load);
    abort = 1'b0;
    @(negedge clk); #1;
    chk("idle_after_done", {busy, done, aborted}, 0);
    chk("rsp_hold", rsp_q, v.rsp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    //           id   op     data  steps ab_at lat en ld up   rsp  ab
    vecs[0] = mk(0, 2'b01, 4'hA, 8'd0, 0, 2, 0, 1, 0, 4'hA, 0);
    vecs[1] = mk(1, 2'b01, 4'hE, 8'd0, 0, 2, 0, 1, 0, 4'hE, 0);
    vecs[2] = mk(1, 2'b10, 4'h0, 8'd3, 0, 4, 3, 0, 1, 4'h1, 0);
    vecs[3] = mk(0, 2'b10, 4'h0, 8'd0, 0, 2, 0, 0, 1, 4'h1, 0);
    vecs[4] = mk(0, 2'b11, 4'h0, 8'd5, 2, 3, 1, 0, 0, 4'h0, 1);
    vecs[5] = mk(0, 2'b00, 4'h7, 8'd4, 0, 2, 0, 0, 0, 4'h0, 0);
    vecs[6] = mk(1, 2'b11, 4'h0, 8'd2, 0, 3, 2, 0, 0, 4'hE, 0);
    vecs[7] = mk(0, 2'b10, 4'h0, 8'd2, 2, 3, 1, 0, 1, 4'hF, 1);
    vecs[8] = mk(1, 2'b01, 4'h3, 8'd0, 1, 2, 0, 0, 0, 4'hF, 1);

    #12;
    chk("reset_values",
        {req_ready, cnt_load, cnt_up, cnt_en, cnt_d, done, aborted, rsp_q, busy}, 0);
    @(negedge clk); reset_n = 1'b1;

    // Round-robin alternation with both requesters continuously valid
    @(negedge clk);
    set_req(0, 2'b00, 4'h0, 8'd0);
    set_req(1, 2'b00, 4'h0, 8'd0);
    req_valid = 2'b11;
    #1 chk("arb_first", req_ready, 2'b01);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); #1;
      case (c)
        1: chk("arb_exec_noready", req_ready, 2'b00);
        2: begin chk("arb_done0", done, 2'b01); chk("arb_done_noready", req_ready, 2'b00); end
        3: chk("arb_second", req_ready, 2'b10);
        5: chk("arb_done1", done, 2'b10);
        6: chk("arb_third", req_ready, 2'b01);
        default: ;
      endcase
    end
    req_valid = '0;

    for (int i = 0; i < 9; i++) run_cmd(vecs[i]);

    // Reset during a long UP command; also leaves requester 0 as last granted
    @(negedge clk);
    set_req(0, 2'b10, 4'h0, 8'd10);
    req_valid = 2'b01;
    #1 chk("rst_accept", req_ready, 2'b01);
    @(negedge clk); req_valid = '0; #1;
    chk("rst_en_before", cnt_en, 1);
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("rst_async_clear", {cnt_en, busy, done}, 0);
    @(negedge clk); reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("rst_no_done", {done, busy}, 0);
    end
    set_req(0, 2'b00, 4'h0, 8'd0);
    set_req(1, 2'b00, 4'h0, 8'd0);
    req_valid = 2'b11;
    #1 chk("rst_rr_priority", req_ready, 2'b01);
    req_valid = '0;

    // Abort while idle has no effect
    abort = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      chk("abort_idle", {busy, done, aborted, cnt_en, cnt_load}, 0);
    end
    abort = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
